tq_tu_sched: RTL and testbench

- Per-TU row scheduler for the rec_tq 2-D transform pipeline.
- On a TU start it issues one row-valid per cycle into the 1-D transform / latency-alignment datapath, and holds the TU size stable for the datapath mux for the whole TU.
- It counts result rows returning from the pipeline and pulses done once every row of the TU has come back.
- Sits between the rec_tq top-level control and the transform datapath.

---
 rtl/tq_tu_sched.sv | 116 +++++++++++
 tb/tb_tq_tu_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tq_tu_sched.sv
// tq_tu_sched: per-TU row scheduler for the rec_tq 2-D transform pipeline.
// Define TQ_TU_SCHED_TIMEOUT_EN to enable the drain watchdog (o_err).
`timescale 1ns/1ps
module tq_tu_sched #(
   parameter int ROW_W  = 5,
   parameter int CNT_W  = 6,
   parameter int TO_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_transize,
   input  logic             i_stall,
   input  logic             i_res_vld,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_row_vld,
   output logic [ROW_W-1:0] o_row_idx,
   output logic [1:0]       o_transize,
   output logic             o_done,
   output logic             o_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] iss_cnt, ret_cnt, rows;
   logic             issue_fire, last_issue, ret_full, ret_count_en, wd_expire;

   // Row count follows the latched size, so it cannot move within a TU.
   assign rows         = CNT_W'(4) << o_transize;
   assign issue_fire   = (state == S_ISSUE) && !i_stall;
   assign last_issue   = issue_fire && (iss_cnt == rows - CNT_W'(1));
   assign ret_full     = (ret_cnt == rows);
   assign ret_count_en = ((state == S_ISSUE) || (state == S_DRAIN)) && i_res_vld && !ret_full;

`ifdef TQ_TU_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TO_CYC + 1);
   logic [WD_W-1:0] wd_cnt;

   // Held at zero outside DRAIN, so it starts from zero on DRAIN entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wd_cnt <= '0;
      else if ((state != S_DRAIN) || i_res_vld)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end

   assign wd_expire = (state == S_DRAIN) && !ret_full && !i_res_vld &&
                      (wd_cnt == WD_W'(TO_CYC - 1));
`else
   logic unused_to_cyc;
   assign unused_to_cyc = |TO_CYC;
   assign wd_expire     = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (i_start) state_nxt = S_ISSUE;
         S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (ret_full)
               state_nxt = S_DONE;
            else if (wd_expire)
               state_nxt = S_IDLE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == S_IDLE);
      o_busy  = (state == S_ISSUE) || (state == S_DRAIN);
   end

   // NOTE: every register takes the async reset, so a mid-TU reset drops all pulses at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_row_vld  <= 1'b0;
         o_row_idx  <= '0;
         o_transize <= '0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         iss_cnt    <= '0;
         ret_cnt    <= '0;
      end else begin
         o_row_vld <= issue_fire;
         o_done    <= (state == S_DRAIN) && ret_full;
         o_err     <= wd_expire;
         if ((state == S_IDLE) && i_start) begin
            o_transize <= i_transize;
            iss_cnt    <= '0;
            ret_cnt    <= '0;
         end
         if (issue_fire) begin
            o_row_idx <= iss_cnt[ROW_W-1:0];
            iss_cnt   <= iss_cnt + CNT_W'(1);
         end
         if (ret_count_en)
            ret_cnt <= ret_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tq_tu_sched.sv
// Bench for tq_tu_sched: directed and random TUs checked against a
// per-TU timing model derived from stall/return histories.
`timescale 1ns/1ps
module tb_tq_tu_sched;

   localparam int N = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic [1:0] i_transize = 2'd0;
   logic       i_stall = 1'b0;
   logic       i_res_vld = 1'b0;
   logic       o_ready, o_busy, o_row_vld, o_done, o_err;
   logic [4:0] o_row_idx;
   logic [1:0] o_transize;

   int         n_chk = 0;
   int         n_pass = 0;
   bit         stall_a [N];
   bit         res_a [N];
   bit         st_a [N];
   logic [1:0] prev_sz = 2'd0;

   tq_tu_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_transize (i_transize),
      .i_stall    (i_stall),
      .i_res_vld  (i_res_vld),
      .o_ready    (o_ready),
      .o_busy     (o_busy),
      .o_row_vld  (o_row_vld),
      .o_row_idx  (o_row_idx),
      .o_transize (o_transize),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},    32'(o_ready), 32'd1);
      check({tag, "_busy"},     32'(o_busy), 32'd0);
      check({tag, "_row_vld"},  32'(o_row_vld), 32'd0);
      check({tag, "_row_idx"},  32'(o_row_idx), 32'd0);
      check({tag, "_transize"}, 32'(o_transize), 32'd0);
      check({tag, "_done"},     32'(o_done), 32'd0);
      check({tag, "_err"},      32'(o_err), 32'd0);
   endtask

   task automatic clear_stim();
      for (int i = 0; i < N; i++) begin
         stall_a[i] = 1'b0;
         res_a[i]   = 1'b0;
         st_a[i]    = 1'b0;
      end
   endtask

   task automatic rand_stim();
      for (int i = 0; i < N; i++) begin
         stall_a[i] = (i < 150) && ($urandom_range(3) == 0);
         res_a[i]   = (i >= 150) || ($urandom_range(1) == 1);
         st_a[i]    = ($urandom_range(7) == 0);
      end
   endtask

   // Start at cycle 0. Row k goes out on the (k+1)-th unstalled cycle from
   // cycle 1 and shows one cycle later. Returns count from cycle 1, so done
   // lands two cycles after the later of last issue and last needed return.
   task automatic run_tu(input logic [1:0] sz);
      int   rows, last_iss, last_ret, done_c, n, issued;
      logic exp_vld;
      rows = 4 << sz;
      last_iss = -1;
      last_ret = -1;
      n = 0;
      for (int c = 1; c < N; c++) begin
         if (!stall_a[c]) n++;
         if (n == rows) begin last_iss = c; break; end
      end
      n = 0;
      for (int c = 1; c < N; c++) begin
         if (res_a[c]) n++;
         if (n == rows) begin last_ret = c; break; end
      end
      if (last_iss < 0 || last_ret < 0) begin
         n_chk++;
         $error("FAIL stim_bound: stimulus too short for %0d rows", rows);
         return;
      end
      done_c = ((last_iss > last_ret) ? last_iss : last_ret) + 2;
      issued = 0;
      for (int c = 0; c <= done_c + 1; c++) begin
         @(posedge clk);
         #1;
         i_start    = (c == 0) || ((c <= done_c) && st_a[c]);
         i_transize = (c == 0) ? sz : 2'($urandom);
         i_stall    = stall_a[c];
         i_res_vld  = res_a[c];
         @(negedge clk);
         exp_vld = 1'b0;
         if (c >= 2 && (c - 1) <= last_iss) exp_vld = !stall_a[c-1];
         check("row_vld", 32'(o_row_vld), 32'(exp_vld));
         if (exp_vld) check("row_idx", 32'(o_row_idx), 32'(issued - 1));
         check("done",  32'(o_done),  32'(c == done_c));
         check("ready", 32'(o_ready), 32'((c == 0) || (c == done_c + 1)));
         check("busy",  32'(o_busy),  32'((c >= 1) && (c < done_c)));
         check("err",   32'(o_err),   32'd0);
         check("transize", 32'(o_transize), 32'((c == 0) ? prev_sz : sz));
         if (c >= 1 && c <= last_iss && !stall_a[c]) issued++;
      end
      prev_sz = sz;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      // 4x4, no stall, returns at cycles 4..7 -> done at cycle 9
      clear_stim();
      for (int c = 4; c <= 7; c++) res_a[c] = 1'b1;
      run_tu(2'd0);

      // 32x32 with stalls at cycles 5 and 6
      clear_stim();
      stall_a[5] = 1'b1;
      stall_a[6] = 1'b1;
      for (int c = 10; c <= 41; c++) res_a[c] = 1'b1;
      run_tu(2'd3);

      // 8x8 with a second start during ISSUE
      clear_stim();
      st_a[3] = 1'b1;
      for (int c = 4; c <= 11; c++) res_a[c] = 1'b1;
      run_tu(2'd1);

      // 8x8 with 10 returns, then a clean follow-on TU
      clear_stim();
      for (int c = 4; c <= 13; c++) res_a[c] = 1'b1;
      run_tu(2'd1);
      clear_stim();
      for (int c = 3; c <= 6; c++) res_a[c] = 1'b1;
      run_tu(2'd0);

      for (int t = 0; t < 12; t++) begin
         rand_stim();
         run_tu(2'($urandom));
      end

      // Reset mid-TU: 16x16, abort after row 5 is shown
      for (int c = 0; c <= 7; c++) begin
         @(posedge clk);
         #1;
         i_start    = (c == 0);
         i_transize = 2'd2;
         i_stall    = 1'b0;
         i_res_vld  = 1'b0;
      end
      @(negedge clk);
      check("pre_rst_row_vld", 32'(o_row_vld), 32'd1);
      check("pre_rst_row_idx", 32'(o_row_idx), 32'd5);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      check_reset_vals("mid_rst_hold");
      rst_n = 1'b1;
      prev_sz = 2'd0;
      clear_stim();
      for (int c = 4; c <= 7; c++) res_a[c] = 1'b1;
      run_tu(2'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
